// File: rtl/reflet_vga_rect_fill_pkg.sv
// Shared types and size helpers for the rectangle-fill engine and its raster counter.
// Widths and grid limits are derived from display size and downscale factor.
package reflet_vga_rect_fill_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StFill = 2'd1,
    StDone = 2'd2
  } fill_state_e;

  function automatic int unsigned calc_hw(input int unsigned h_size, input int unsigned bit_red);
    return $clog2(h_size) - bit_red;
  endfunction

  function automatic int unsigned calc_vw(input int unsigned v_line, input int unsigned bit_red);
    return $clog2(v_line) - bit_red;
  endfunction

  function automatic int unsigned calc_hmax(input int unsigned h_size, input int unsigned bit_red);
    return (h_size >> bit_red) - 1;
  endfunction

  function automatic int unsigned calc_vmax(input int unsigned v_line, input int unsigned bit_red);
    return (v_line >> bit_red) - 1;
  endfunction

  localparam int unsigned HMaxDefault = calc_hmax(640, 0);
  localparam int unsigned VMaxDefault = calc_vmax(480, 0);

endpackage

// File: rtl/reflet_vga_rect_fill_if.sv
// Command side and bitmap write port of the rectangle-fill engine.
interface reflet_vga_rect_fill_if #(
  parameter int unsigned HSize        = 640,
  parameter int unsigned VLine        = 480,
  parameter int unsigned ColorDepth   = 8,
  parameter int unsigned BitReduction = 0
);
  localparam int unsigned Hw = reflet_vga_rect_fill_pkg::calc_hw(HSize, BitReduction);
  localparam int unsigned Vw = reflet_vga_rect_fill_pkg::calc_vw(VLine, BitReduction);

  logic                  start;
  logic                  abort;
  logic [Hw-1:0]         x0;
  logic [Hw-1:0]         x1;
  logic [Vw-1:0]         y0;
  logic [Vw-1:0]         y1;
  logic [ColorDepth-1:0] r_fill;
  logic [ColorDepth-1:0] g_fill;
  logic [ColorDepth-1:0] b_fill;
  logic [ColorDepth-1:0] a_fill;
  logic                  write_grant;
  logic                  busy;
  logic                  done;
  logic                  write_en;
  logic [Hw-1:0]         h_pixel_in;
  logic [Vw-1:0]         v_pixel_in;
  logic [ColorDepth-1:0] r_in;
  logic [ColorDepth-1:0] g_in;
  logic [ColorDepth-1:0] b_in;
  logic [ColorDepth-1:0] a_in;

  modport slave (
    input  start, abort, x0, x1, y0, y1, r_fill, g_fill, b_fill, a_fill, write_grant,
    output busy, done, write_en, h_pixel_in, v_pixel_in, r_in, g_in, b_in, a_in
  );

  modport master (
    output start, abort, x0, x1, y0, y1, r_fill, g_fill, b_fill, a_fill, write_grant,
    input  busy, done, write_en, h_pixel_in, v_pixel_in, r_in, g_in, b_in, a_in
  );

endinterface

// File: rtl/reflet_vga_rect_fill_raster_counter.sv
// Raster-order x/y counter over an inclusive box; loads bounds, advances one pixel per
// request and flags the last pixel. Holds at the last pixel instead of wrapping.
module reflet_vga_rect_fill_raster_counter #(
  parameter int unsigned Hw = 10,
  parameter int unsigned Vw = 9
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_i,
  input  logic          advance_i,
  input  logic [Hw-1:0] xmin_i,
  input  logic [Hw-1:0] xmax_i,
  input  logic [Vw-1:0] ymin_i,
  input  logic [Vw-1:0] ymax_i,
  output logic [Hw-1:0] x_o,
  output logic [Vw-1:0] y_o,
  output logic          last_o
);

  logic [Hw-1:0] x_q, x_d, xmin_q, xmin_d, xmax_q, xmax_d;
  logic [Vw-1:0] y_q, y_d, ymax_q, ymax_d;

  assign last_o = (x_q == xmax_q) && (y_q == ymax_q);
  assign x_o    = x_q;
  assign y_o    = y_q;

  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    xmin_d = xmin_q;
    xmax_d = xmax_q;
    ymax_d = ymax_q;
    if (load_i) begin
      x_d    = xmin_i;
      y_d    = ymin_i;
      xmin_d = xmin_i;
      xmax_d = xmax_i;
      ymax_d = ymax_i;
    end else if (advance_i && !last_o) begin
      if (x_q < xmax_q) begin
        x_d = x_q + 1'b1;
      end else begin
        x_d = xmin_q;
        y_d = y_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_q    <= '0;
      y_q    <= '0;
      xmin_q <= '0;
      xmax_q <= '0;
      ymax_q <= '0;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      xmin_q <= xmin_d;
      xmax_q <= xmax_d;
      ymax_q <= ymax_d;
    end
  end

endmodule

// File: rtl/reflet_vga_rect_fill.sv
// Rectangle-fill engine: sorts and clips two corners, then writes one pixel of a latched
// colour per granted cycle in raster order onto the bitmap write port.
module reflet_vga_rect_fill
  import reflet_vga_rect_fill_pkg::*;
#(
  parameter int unsigned HSize        = 640,
  parameter int unsigned VLine        = 480,
  parameter int unsigned ColorDepth   = 8,
  parameter int unsigned BitReduction = 0
) (
  input logic                  clk,
  input logic                  reset,
  reflet_vga_rect_fill_if.slave bus
);

  localparam int unsigned Hw = calc_hw(HSize, BitReduction);
  localparam int unsigned Vw = calc_vw(VLine, BitReduction);
  localparam logic [Hw-1:0] HMax = Hw'(calc_hmax(HSize, BitReduction));
  localparam logic [Vw-1:0] VMax = Vw'(calc_vmax(VLine, BitReduction));
  localparam int unsigned Cw = 4 * ColorDepth;

  fill_state_e   state_q, state_d;
  logic [Cw-1:0] colour_q, colour_d;
  logic [Hw-1:0] xlo, xhi, x;
  logic [Vw-1:0] ylo, yhi, y;
  logic          load, advance, last;

  // Corner sort and clip; only consumed on the start cycle.
  always_comb begin
    xlo = (bus.x0 < bus.x1) ? bus.x0 : bus.x1;
    xhi = (bus.x0 < bus.x1) ? bus.x1 : bus.x0;
    ylo = (bus.y0 < bus.y1) ? bus.y0 : bus.y1;
    yhi = (bus.y0 < bus.y1) ? bus.y1 : bus.y0;
    if (xlo > HMax) xlo = HMax;
    if (xhi > HMax) xhi = HMax;
    if (ylo > VMax) ylo = VMax;
    if (yhi > VMax) yhi = VMax;
  end

  always_comb begin
    state_d  = state_q;
    colour_d = colour_q;
    load     = 1'b0;
    advance  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          load     = 1'b1;
          colour_d = {bus.r_fill, bus.g_fill, bus.b_fill, bus.a_fill};
          state_d  = StFill;
        end
      end
      StFill: begin
        advance = bus.write_grant;
        // Abort beats completion even when the last pixel is written this cycle.
        if (bus.abort) begin
          state_d = StIdle;
        end else if (bus.write_grant && last) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      colour_q <= '0;
    end else begin
      state_q  <= state_d;
      colour_q <= colour_d;
    end
  end

  reflet_vga_rect_fill_raster_counter #(
    .Hw(Hw),
    .Vw(Vw)
  ) u_counter (
    .clk      (clk),
    .reset    (reset),
    .load_i   (load),
    .advance_i(advance),
    .xmin_i   (xlo),
    .xmax_i   (xhi),
    .ymin_i   (ylo),
    .ymax_i   (yhi),
    .x_o      (x),
    .y_o      (y),
    .last_o   (last)
  );

  assign bus.busy       = (state_q == StFill);
  assign bus.done       = (state_q == StDone);
  assign bus.write_en   = (state_q == StFill) && bus.write_grant;
  assign bus.h_pixel_in = x;
  assign bus.v_pixel_in = y;
  assign bus.r_in       = colour_q[4*ColorDepth-1:3*ColorDepth];
  assign bus.g_in       = colour_q[3*ColorDepth-1:2*ColorDepth];
  assign bus.b_in       = colour_q[2*ColorDepth-1:ColorDepth];
  assign bus.a_in       = colour_q[ColorDepth-1:0];

endmodule

// File: tb/tb_reflet_vga_rect_fill.sv
// Bench for the rectangle-fill engine at 640x480 with a 2x downscale (320x240 grid).
module tb_reflet_vga_rect_fill;

  localparam int unsigned HSize        = 640;
  localparam int unsigned VLine        = 480;
  localparam int unsigned ColorDepth   = 8;
  localparam int unsigned BitReduction = 1;
  localparam int HMaxI = 319;
  localparam int VMaxI = 239;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  reflet_vga_rect_fill_if #(
    .HSize(HSize), .VLine(VLine), .ColorDepth(ColorDepth), .BitReduction(BitReduction)
  ) bus ();

  reflet_vga_rect_fill #(
    .HSize(HSize), .VLine(VLine), .ColorDepth(ColorDepth), .BitReduction(BitReduction)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    int x0, x1, y0, y1;
    logic [31:0] col;
    int n, fx, fy, lx, ly;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] colour_out();
    return {bus.r_in, bus.g_in, bus.b_in, bus.a_in};
  endfunction

  // Drives one fill and checks every cycle against a pixel list built from the corner rules.
  task automatic run_fill(input int a0, input int a1, input int b0, input int b1,
                          input logic [31:0] col, input bit ab, input int pct,
                          input logic [31:0] gpat, input int glen,
                          output int nw, output int done_idx,
                          output int fx, output int fy, output int lx, output int ly);
    int q[$];
    int xl, xh, yl, yh, i, budget;
    bit g, fin;
    xl = (a0 < a1) ? a0 : a1;  xh = (a0 < a1) ? a1 : a0;
    yl = (b0 < b1) ? b0 : b1;  yh = (b0 < b1) ? b1 : b0;
    if (xl > HMaxI) xl = HMaxI;
    if (xh > HMaxI) xh = HMaxI;
    if (yl > VMaxI) yl = VMaxI;
    if (yh > VMaxI) yh = VMaxI;
    for (int yy = yl; yy <= yh; yy++)
      for (int xx = xl; xx <= xh; xx++) q.push_back(xx * 65536 + yy);
    budget = q.size() * 30 + 50;
    nw = 0; done_idx = -1; fx = -1; fy = -1; lx = -1; ly = -1;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.abort = ab;
    bus.x0 = 9'(a0); bus.x1 = 9'(a1); bus.y0 = 8'(b0); bus.y1 = 8'(b1);
    {bus.r_fill, bus.g_fill, bus.b_fill, bus.a_fill} = col;
    bus.write_grant = 1'b1;
    @(negedge clk);
    chk("start_cycle_we", {31'b0, bus.write_en}, 0);
    chk("start_cycle_busy", {31'b0, bus.busy}, 0);
    fin = 1'b0; i = 0;
    while (!fin && i < budget) begin
      @(posedge clk); #1;
      bus.start = 1'b0; bus.abort = 1'b0;
      // Corner and colour inputs wander during the fill; they must not matter.
      bus.x0 = 9'($urandom_range(0, 511)); bus.y1 = 8'($urandom_range(0, 255));
      bus.r_fill = 8'($urandom_range(0, 255));
      g = (i < glen) ? gpat[i] : ($urandom_range(0, 99) < pct);
      bus.write_grant = g;
      @(negedge clk);
      if (bus.write_en) begin
        if (nw == 0) begin fx = int'(bus.h_pixel_in); fy = int'(bus.v_pixel_in); end
        lx = int'(bus.h_pixel_in); ly = int'(bus.v_pixel_in);
        nw++;
      end
      if (bus.done && done_idx < 0) done_idx = i;
      if (q.size() > 0) begin
        chk("fill_busy", {31'b0, bus.busy}, 1);
        chk("fill_done", {31'b0, bus.done}, 0);
        chk("fill_we", {31'b0, bus.write_en}, {31'b0, g});
        chk("fill_hpix", {23'b0, bus.h_pixel_in}, q[0] >> 16);
        chk("fill_vpix", {24'b0, bus.v_pixel_in}, q[0] & 32'hFFFF);
        if (g) begin
          chk("fill_colour", colour_out(), col);
          void'(q.pop_front());
        end
      end else begin
        chk("end_done", {31'b0, bus.done}, 1);
        chk("end_busy", {31'b0, bus.busy}, 0);
        chk("end_we", {31'b0, bus.write_en}, 0);
        fin = 1'b1;
      end
      i++;
    end
    if (!fin) chk("fill_timeout", 0, 1);
    @(posedge clk); #1;
    bus.write_grant = 1'b0;
    @(negedge clk);
    chk("done_single_pulse", {31'b0, bus.done}, 0);
    chk("idle_after_done", {31'b0, bus.busy}, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  initial begin
    vec_t tbl[7];
    int nw, di, fx, fy, lx, ly;
    tbl[0] = '{5, 5, 7, 7, 32'h112233FF, 1, 5, 7, 5, 7};
    tbl[1] = '{3, 1, 1, 0, 32'hA0B0C0D0, 6, 1, 0, 3, 1};
    tbl[2] = '{310, 400, 10, 11, 32'h01020304, 20, 310, 10, 319, 11};
    tbl[3] = '{0, 2, 250, 237, 32'hFFEEDDCC, 9, 0, 237, 2, 239};
    tbl[4] = '{400, 330, 245, 250, 32'h55AA55AA, 1, 319, 239, 319, 239};
    tbl[5] = '{0, 0, 0, 3, 32'h0F0F0F0F, 4, 0, 0, 0, 3};
    tbl[6] = '{7, 0, 2, 2, 32'h12345678, 8, 0, 2, 7, 2};

    bus.start = 0; bus.abort = 0; bus.write_grant = 0;
    bus.x0 = 0; bus.x1 = 0; bus.y0 = 0; bus.y1 = 0;
    bus.r_fill = 0; bus.g_fill = 0; bus.b_fill = 0; bus.a_fill = 0;

    repeat (2) @(negedge clk);
    chk("rst_busy", {31'b0, bus.busy}, 0);
    chk("rst_done", {31'b0, bus.done}, 0);
    chk("rst_we", {31'b0, bus.write_en}, 0);
    chk("rst_hpix", {23'b0, bus.h_pixel_in}, 0);
    chk("rst_vpix", {24'b0, bus.v_pixel_in}, 0);
    chk("rst_colour", colour_out(), 0);
    #2 reset = 1'b1;

    for (int k = 0; k < 7; k++) begin
      run_fill(tbl[k].x0, tbl[k].x1, tbl[k].y0, tbl[k].y1, tbl[k].col, 1'b0, 100, 32'h0, 0,
               nw, di, fx, fy, lx, ly);
      chk($sformatf("vec%0d_writes", k), nw, tbl[k].n);
      chk($sformatf("vec%0d_done_cycle", k), di, tbl[k].n);
      chk($sformatf("vec%0d_first_x", k), fx, tbl[k].fx);
      chk($sformatf("vec%0d_first_y", k), fy, tbl[k].fy);
      chk($sformatf("vec%0d_last_x", k), lx, tbl[k].lx);
      chk($sformatf("vec%0d_last_y", k), ly, tbl[k].ly);
    end

    // Grant pattern 1,0,0,1,1,0,1 on a 2x2 box.
    run_fill(4, 5, 9, 10, 32'hCAFEF00D, 1'b0, 100, 32'b1011001, 7, nw, di, fx, fy, lx, ly);
    chk("throttle_writes", nw, 4);
    chk("throttle_done_cycle", di, 7);

    // Start and abort together while idle: start wins.
    run_fill(20, 21, 30, 30, 32'h0BADBEEF, 1'b1, 100, 32'h0, 0, nw, di, fx, fy, lx, ly);
    chk("start_abort_writes", nw, 2);

    // Abort after three writes of a 4x4, with a competing start mid-fill.
    @(posedge clk); #1;
    bus.start = 1; bus.x0 = 10; bus.x1 = 13; bus.y0 = 20; bus.y1 = 23; bus.write_grant = 1;
    {bus.r_fill, bus.g_fill, bus.b_fill, bus.a_fill} = 32'h44332211;
    @(posedge clk); #1; bus.start = 0;
    @(negedge clk);
    chk("abort_w1_we", {31'b0, bus.write_en}, 1);
    chk("abort_w1_h", {23'b0, bus.h_pixel_in}, 10);
    @(posedge clk); #1; bus.start = 1; bus.x0 = 100; bus.x1 = 101; bus.y0 = 100; bus.y1 = 100;
    @(negedge clk);
    chk("abort_w2_h", {23'b0, bus.h_pixel_in}, 11);
    @(posedge clk); #1; bus.start = 0; bus.abort = 1;
    @(negedge clk);
    chk("abort_w3_we", {31'b0, bus.write_en}, 1);
    chk("abort_w3_h", {23'b0, bus.h_pixel_in}, 12);
    chk("abort_w3_v", {24'b0, bus.v_pixel_in}, 20);
    @(posedge clk); #1; bus.abort = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("after_abort_busy", {31'b0, bus.busy}, 0);
      chk("after_abort_we", {31'b0, bus.write_en}, 0);
      chk("after_abort_done", {31'b0, bus.done}, 0);
      @(posedge clk); #1;
    end

    // Abort on the last write suppresses done.
    bus.start = 1; bus.x0 = 0; bus.x1 = 1; bus.y0 = 0; bus.y1 = 0; bus.write_grant = 1;
    @(posedge clk); #1; bus.start = 0;
    @(posedge clk); #1; bus.abort = 1;
    @(negedge clk);
    chk("abort_last_we", {31'b0, bus.write_en}, 1);
    chk("abort_last_h", {23'b0, bus.h_pixel_in}, 1);
    @(posedge clk); #1; bus.abort = 0;
    @(negedge clk);
    chk("abort_last_no_done", {31'b0, bus.done}, 0);
    chk("abort_last_busy", {31'b0, bus.busy}, 0);

    // Asynchronous reset between clock edges mid-fill.
    @(posedge clk); #1;
    bus.start = 1; bus.x0 = 0; bus.x1 = 3; bus.y0 = 0; bus.y1 = 3; bus.write_grant = 1;
    @(posedge clk); #1; bus.start = 0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("pre_reset_busy", {31'b0, bus.busy}, 1);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_we", {31'b0, bus.write_en}, 0);
    chk("async_rst_busy", {31'b0, bus.busy}, 0);
    chk("async_rst_hpix", {23'b0, bus.h_pixel_in}, 0);
    @(negedge clk);
    #2 reset = 1'b1;
    bus.write_grant = 0;
    run_fill(2, 3, 5, 6, 32'h99887766, 1'b0, 100, 32'h0, 0, nw, di, fx, fy, lx, ly);
    chk("post_reset_writes", nw, 4);

    for (int r = 0; r < 20; r++) begin
      int a0, a1, b0, b1;
      if ($urandom_range(0, 3) == 0) begin
        a0 = $urandom_range(300, 511); a1 = $urandom_range(300, 511);
        b0 = $urandom_range(228, 255); b1 = $urandom_range(228, 255);
      end else begin
        a0 = $urandom_range(0, 300); a1 = a0 + $urandom_range(0, 6);
        b0 = $urandom_range(0, 220); b1 = b0 + $urandom_range(0, 6);
        if ($urandom_range(0, 1) == 1) begin int t = a0; a0 = a1; a1 = t; end
      end
      run_fill(a0, a1, b0, b1, $urandom, 1'($urandom_range(0, 1)), $urandom_range(40, 100),
               32'h0, 0, nw, di, fx, fy, lx, ly);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reflet_vga_rect_fill.md
Name: reflet_VGA_rect_fill

Overview:
- Rectangle-fill write engine for the bitmap frame buffer.
- Accepts a rectangle (two inclusive corners) and one RGBA colour.
- Drives the bitmap write port (write_en, h/v pixel address, R/G/B/a), one pixel per granted cycle, in raster order.
- Sits between the CPU/command interface and the bitmap memory. A write_grant input allows an arbiter to share the write port with other writers.

Parameters:
- h_size, 640: horizontal resolution in display pixels.
- v_line, 480: vertical resolution in display lines.
- color_depth, 8: bits per colour channel.
- bit_reduction, 0: log2 of the downscale factor. Stored grid is (h_size>>bit_reduction) x (v_line>>bit_reduction).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a fill. Sampled only in IDLE.
- abort  in  1  synchronous cancel of a fill in progress.
- x0, x1  in  HW  horizontal corners, inclusive. HW = $clog2(h_size)-bit_reduction.
- y0, y1  in  VW  vertical corners, inclusive. VW = $clog2(v_line)-bit_reduction.
- R_fill, G_fill, B_fill, a_fill  in  color_depth each  fill colour, sampled with start.
- write_grant  in  1  write port granted this cycle.
- busy  out  1  high in FILL.
- done  out  1  one-cycle pulse after the last pixel is written.
- write_en  out  1  to bitmap write_en.
- h_pixel_in  out  HW  to bitmap write x.
- v_pixel_in  out  VW  to bitmap write y.
- R_in, G_in, B_in, a_in  out  color_depth each  to bitmap colour inputs.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE. All counters, latched corners and latched colour are 0. busy=0, done=0, write_en=0, h_pixel_in=0, v_pixel_in=0, colour outputs=0. A reset asserted mid-fill cancels immediately, with no done pulse.
- States: IDLE, FILL, DONE.
- IDLE, on start=1:
  - latch xmin=min(x0,x1), xmax=max(x0,x1), ymin=min(y0,y1), ymax=max(y0,y1), and the colour;
  - clip xmax to HMAX=(h_size>>bit_reduction)-1 and ymax to VMAX=(v_line>>bit_reduction)-1; also clip xmin/ymin;
  - load x=xmin, y=ymin; go to FILL.
- FILL:
  - write_en = write_grant (combinational AND with state==FILL).
  - h_pixel_in=x and v_pixel_in=y are registered counters. Colour outputs are the latched colour.
  - On a granted cycle: if x<xmax then x++; else x=xmin and y++.
  - On the granted write at (xmax,ymax): go to DONE.
  - write_grant=0: hold x, y, state; write_en=0.
- DONE: done=1 for one cycle, busy=0, write_en=0, then IDLE.
- abort=1 in FILL: go to IDLE next edge, no done pulse. A write granted in that same cycle still occurs. abort has priority over the DONE transition.
- start while busy or in DONE: ignored. No queuing.
- start and abort together in IDLE: start wins; abort is ignored in IDLE.
- Latency: start in cycle N gives the first write_en in cycle N+1, provided grant is held. With grant high throughout, W*H writes occur in cycles N+1..N+W*H, and done is high in cycle N+W*H+1. W=xmax-xmin+1, H=ymax-ymin+1.
- Degenerate rectangle x0==x1 and y0==y1: exactly one write.
- Address arithmetic is unsigned, HW/VW bits. Counters never exceed xmax/ymax, so no wrap.
- Corners are not re-sampled during FILL; input changes have no effect.

Decomposition:
- Shared package reflet_VGA_pkg holds:
  - width functions HW/VW (from h_size, v_line, bit_reduction);
  - HMAX/VMAX constants;
  - the fill-state enum (IDLE/FILL/DONE).
- One natural sub-module: reflet_VGA_raster_counter. It is the x/y counter pair with load(xmin,ymin), advance, bounds and a last flag. It is reusable by a future blit/copy engine.
- Output is wired directly to the bitmap module's write port. No extra buffering.

Test Plan:
- Single pixel: start with x0=x1=5, y0=y1=7, colour R=0x11 G=0x22 B=0x33 a=0xFF, grant=1 -> exactly one write_en at (5,7) with that colour in cycle N+1; done high in cycle N+2; busy high in N+1 only.
- Swapped corners: x0=3,x1=1,y0=1,y1=0 -> 6 writes in order (1,0)(2,0)(3,0)(1,1)(2,1)(3,1); done 7 cycles after start; memory readback matches.
- Grant throttling: 2x2 rectangle with grant pattern 1,0,0,1,1,0,1 -> 4 writes only on grant cycles; address held across gaps; done one cycle after the fourth write.
- Clipping (h_size=640, bit_reduction=1): x1=400 -> last column written is 319; no write with h_pixel_in>319.
- Abort and busy-start: abort after 3 writes of a 4x4 fill -> no further writes, no done, busy=0 next cycle. A start pulsed mid-fill is ignored (the write count is unchanged).
- Async reset mid-fill: drive reset low between clock edges -> write_en and busy go 0 without waiting for a clock edge. After reset release, a new start fills correctly.
